// File: rtl/btn_hex_counter_if.sv
// -----------------------------------------------------------------------------
// btn_hex_counter_if
// Groups the button-counter bus into one bundle.
//   btn  [3:0]  raw push-button levels (asynchronous to clk, active-high)
//   dec         step direction: 0 = increment, 1 = decrement
//   clr         synchronous clear of num, highest priority
//   num  [15:0] four-digit hex value, feeds the display driver hexs input
//   step [3:0]  one-cycle pulse per digit in the cycle that digit changes
// master: drives btn/dec/clr (board / bench side)
// slave : the counter itself
// -----------------------------------------------------------------------------
interface btn_hex_counter_if;
    logic [3:0]  btn;
    logic        dec;
    logic        clr;
    logic [15:0] num;
    logic [3:0]  step;

    modport master (
        output btn,
        output dec,
        output clr,
        input  num,
        input  step
    );

    modport slave (
        input  btn,
        input  dec,
        input  clr,
        output num,
        output step
    );
endinterface

// File: rtl/btn_hex_counter.sv
// -----------------------------------------------------------------------------
// btn_hex_counter
// Synchronises and debounces four raw push-buttons; each accepted press steps
// one hex digit of num up or down (4-bit wrap, no carry between digits).
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    btn_hex_counter_if.slave (btn, dec, clr in; num, step out)
//
// Optional build macro: BTN_HEX_COUNTER_AUTO_REPEAT_EN
//   When defined, a held button re-steps its digit REPEAT_DELAY cycles after
//   the initial step and then every REPEAT_PERIOD cycles until released.
//   When undefined, exactly one step per press; REPEAT_* are accepted unused.
// -----------------------------------------------------------------------------
module btn_hex_counter #(
    parameter int unsigned      CNT_W           = 20,
    parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 20'd1_000_000,
    parameter logic [25:0]      REPEAT_DELAY    = 26'd50_000_000,
    parameter logic [25:0]      REPEAT_PERIOD   = 26'd10_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    btn_hex_counter_if.slave    bus
);

    // Counter value on which the new level is accepted.
    localparam logic [CNT_W-1:0] DB_LAST = DEBOUNCE_CYCLES - CNT_W'(1);

    // Modulo-16 step of a single digit.
    function automatic logic [3:0] step_digit(input logic [3:0] digit, input logic down);
        logic [3:0] res;
        if (down) begin
            res = digit - 4'd1;
        end else begin
            res = digit + 4'd1;
        end
        return res;
    endfunction

    logic [3:0]       s1_r;
    logic [3:0]       s2_r;
    logic [3:0]       lvl_r;
    logic [3:0]       lvl_d_r;
    logic [CNT_W-1:0] cnt_r [0:3];
    logic [3:0]       press_s;
    logic [3:0]       req_s;
    logic [15:0]      num_nxt_s;
    logic [3:0]       step_nxt_s;
    logic [15:0]      num_r;
    logic [3:0]       step_r;

    // Two-flop synchroniser for the asynchronous button levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= 4'b0000;
            s2_r <= 4'b0000;
        end else begin
            s1_r <= bus.btn;
            s2_r <= s1_r;
        end
    end

    // Per-channel debounce: a new level must persist DEBOUNCE_CYCLES edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
            lvl_r <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s2_r[i] == lvl_r[i]) begin
                    cnt_r[i] <= {CNT_W{1'b0}};
                end else if (cnt_r[i] == DB_LAST) begin
                    lvl_r[i] <= s2_r[i];
                    cnt_r[i] <= {CNT_W{1'b0}};
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                end
            end
        end
    end

    // Delayed copy of the stable level for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_d_r <= 4'b0000;
        end else begin
            lvl_d_r <= lvl_r;
        end
    end

    // A press is requested for exactly the one cycle after lvl rises.
    assign press_s = lvl_r & ~lvl_d_r;

`ifdef BTN_HEX_COUNTER_AUTO_REPEAT_EN
    // tmr_r counts cycles since the last step of that digit; phase_r marks
    // that the first (longer) repeat delay has already elapsed.
    logic [25:0] tmr_r [0:3];
    logic [3:0]  phase_r;
    logic [3:0]  rpt_s;

    // Repeat request once the hold timer reaches the active interval.
    always_comb begin
        rpt_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (lvl_r[i] && ((phase_r[i] && (tmr_r[i] == REPEAT_PERIOD)) ||
                             (!phase_r[i] && (tmr_r[i] == REPEAT_DELAY)))) begin
                rpt_s[i] = 1'b1;
            end else begin
                rpt_s[i] = 1'b0;
            end
        end
    end

    // Hold timers: restart on every step, clear on release or clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                tmr_r[i] <= 26'd0;
            end
            phase_r <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!lvl_r[i] || bus.clr) begin
                    tmr_r[i]   <= 26'd0;
                    phase_r[i] <= 1'b0;
                end else if (press_s[i]) begin
                    tmr_r[i]   <= 26'd1;
                    phase_r[i] <= 1'b0;
                end else if (rpt_s[i]) begin
                    tmr_r[i]   <= 26'd1;
                    phase_r[i] <= 1'b1;
                end else begin
                    tmr_r[i]   <= tmr_r[i] + 26'd1;
                end
            end
        end
    end

    assign req_s = press_s | rpt_s;
`else
    // Repeat timing is accepted for build compatibility but has no effect.
    logic unused_repeat_s;
    assign unused_repeat_s = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign req_s           = press_s;
`endif

    // Next digit values; clr wins and discards any request in that cycle.
    always_comb begin
        num_nxt_s  = num_r;
        step_nxt_s = 4'b0000;
        if (bus.clr) begin
            num_nxt_s  = 16'h0000;
            step_nxt_s = 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (req_s[i]) begin
                    num_nxt_s[4*i +: 4] = step_digit(num_r[4*i +: 4], bus.dec);
                    step_nxt_s[i]       = 1'b1;
                end else begin
                    num_nxt_s[4*i +: 4] = num_r[4*i +: 4];
                    step_nxt_s[i]       = 1'b0;
                end
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_r  <= 16'h0000;
            step_r <= 4'b0000;
        end else begin
            num_r  <= num_nxt_s;
            step_r <= step_nxt_s;
        end
    end

    assign bus.num  = num_r;
    assign bus.step = step_r;

endmodule

// File: tb/tb_btn_hex_counter.sv
// -----------------------------------------------------------------------------
// tb_btn_hex_counter
// Directed bench for btn_hex_counter with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8,
// REPEAT_PERIOD=3. Expected step events go into a queue when a press is
// driven; a negedge monitor pops and compares each step pulse it observes.
// Honours BTN_HEX_COUNTER_AUTO_REPEAT_EN for the held-button scenario.
// -----------------------------------------------------------------------------
module tb_btn_hex_counter;

    logic clk = 1'b0;
    logic rst_n;

    btn_hex_counter_if bus();

    btn_hex_counter #(
        .CNT_W           (20),
        .DEBOUNCE_CYCLES (20'd4),
        .REPEAT_DELAY    (26'd8),
        .REPEAT_PERIOD   (26'd3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] num;
        logic [3:0]  step;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] model_num = 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference digit arithmetic: each selected digit moves by one, mod 16.
    function automatic logic [15:0] model_step(input logic [15:0] n, input logic [3:0] mask,
                                               input logic down);
        logic [15:0] r;
        logic [3:0]  d;
        r = n;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                d = r[4*i +: 4];
                d = down ? ((d == 4'h0) ? 4'hF : d - 4'h1)
                         : ((d == 4'hF) ? 4'h0 : d + 4'h1);
                r[4*i +: 4] = d;
            end
        end
        return r;
    endfunction

    task automatic expect_step(input logic [3:0] mask, input logic down);
        model_num = model_step(model_num, mask, down);
        exp_q.push_back({model_num, mask});
    endtask

    // Monitor: every step pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.step !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_step", {28'd0, bus.step}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_step", {28'd0, bus.step}, {28'd0, e.step});
                chk("sb_num", {16'd0, bus.num}, {16'd0, e.num});
            end
        end
    end

    task automatic wait_drain(input string tag);
        for (int k = 0; k < 40; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk(tag, exp_q.size(), 32'd0);
    endtask

    task automatic release_btn();
        @(negedge clk);
        bus.btn = 4'b0000;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_num", {16'd0, bus.num}, 32'd0);
        chk("rst_step", {28'd0, bus.step}, 32'd0);
        exp_q.delete();
        model_num = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] mask, input logic down, input string tag);
        @(negedge clk);
        bus.dec = down;
        bus.btn = bus.btn | mask;
        expect_step(mask, down);
        wait_drain(tag);
        release_btn();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        bus.btn = 4'b0000;
        bus.dec = 1'b0;
        bus.clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("init_num", {16'd0, bus.num}, 32'd0);
        chk("init_step", {28'd0, bus.step}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press of btn[0]: update on the 7th edge after the level change.
        @(negedge clk);
        bus.btn = 4'b0001;
        expect_step(4'b0001, 1'b0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("lat_pre_step", {28'd0, bus.step}, 32'd0);
        chk("lat_pre_num", {16'd0, bus.num}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_step", {28'd0, bus.step}, 32'h1);
        chk("lat_num", {16'd0, bus.num}, 32'h1);
`ifdef BTN_HEX_COUNTER_AUTO_REPEAT_EN
        // Repeats at hold offsets 8, 11, 14, 17, 20; release so lvl falls first.
        for (int k = 0; k < 5; k++) expect_step(4'b0001, 1'b0);
        repeat (16) @(posedge clk);
`else
        repeat (20) @(posedge clk);
`endif
        @(negedge clk);
        bus.btn = 4'b0000;
        repeat (10) @(negedge clk);
        wait_drain("hold_drain");
`ifdef BTN_HEX_COUNTER_AUTO_REPEAT_EN
        chk("hold_num", {16'd0, bus.num}, 32'h0006);
`else
        chk("hold_num", {16'd0, bus.num}, 32'h0001);
`endif

        // Bounce on btn[2]: 2-cycle toggles never survive, then settle high.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.btn[2] = (k % 2 == 0);
            @(negedge clk);
        end
        chk("bounce_quiet_num", {16'd0, bus.num}, 32'd0);
        press(4'b0100, 1'b0, "bounce_drain");
        chk("bounce_num", {16'd0, bus.num}, 32'h0100);

        // Wrap on digit 3: sixteen increments, then one decrement.
        do_reset();
        for (int k = 0; k < 16; k++) press(4'b1000, 1'b0, "wrap_drain");
        chk("wrap_up_num", {16'd0, bus.num}, 32'h0000);
        press(4'b1000, 1'b1, "wrap_dn_drain");
        chk("wrap_dn_num", {16'd0, bus.num}, 32'hF000);

        // Simultaneous press on digits 0 and 1.
        do_reset();
        press(4'b0011, 1'b0, "simul_drain");
        chk("simul_num", {16'd0, bus.num}, 32'h0011);

        // Same press with clr in the update cycle: cleared, no step.
        @(negedge clk);
        bus.btn = 4'b0011;
        repeat (6) @(posedge clk);
        @(negedge clk);
        bus.clr = 1'b1;
        @(posedge clk);
        #1;
        chk("clr_num", {16'd0, bus.num}, 32'h0000);
        chk("clr_step", {28'd0, bus.step}, 32'h0);
        @(negedge clk);
        bus.clr   = 1'b0;
        model_num = 16'h0000;
        repeat (5) @(negedge clk);
        release_btn();
        chk("clr_after_num", {16'd0, bus.num}, 32'h0000);

        // Reset in the middle of debouncing btn[1].
        do_reset();
        press(4'b0001, 1'b0, "mid_pre_drain");
        chk("mid_pre_num", {16'd0, bus.num}, 32'h0001);
        @(negedge clk);
        bus.btn = 4'b0010;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_async_num", {16'd0, bus.num}, 32'h0000);
        chk("mid_async_step", {28'd0, bus.step}, 32'h0);
        exp_q.delete();
        model_num = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        expect_step(4'b0010, 1'b0);
        wait_drain("mid_drain");
        chk("mid_num", {16'd0, bus.num}, 32'h0010);
        release_btn();
        chk("final_num", {16'd0, bus.num}, 32'h0010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btn_hex_counter.md
Name: btn_hex_counter

Overview:
- Upstream producer of the 16-bit value shown on the 4-digit seven-segment display.
- Takes four raw board push-buttons and synchronises and debounces each one.
- Each debounced press increments, or decrements, one hex digit of `num`.
- `num` connects directly to the display driver's `hexs` input.

Parameters:
- DEBOUNCE_CYCLES, 20'd1_000_000, number of consecutive stable clk cycles before a button level is accepted (10 ms at 100 MHz).
- CNT_W, 20, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- REPEAT_DELAY, 26'd50_000_000, hold time before auto-repeat begins (used only with the optional feature).
- REPEAT_PERIOD, 26'd10_000_000, interval between auto-repeat steps (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn  input  4  raw button levels, asynchronous to clk, active-high; btn[i] controls digit i, i.e. num[4i+3:4i].
- dec  input  1  step direction: 0 = increment, 1 = decrement; sampled in the cycle a step is applied.
- clr  input  1  synchronous clear of num; highest priority.
- num  output  16  current four-digit hex value.
- step  output  4  one-cycle pulse per digit, asserted in the cycle that digit changes.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Clears num=16'h0000, step=4'b0000, all synchronisers, debounce counters and stable levels.
  - Clears any auto-repeat timers.
  - State resumes on the first rising clk edge after rst_n rises.
- Synchroniser: a two-flop chain per bit, btn -> s1 -> s2.
- Debounce, per button, independent channels:
  - Hold a stable level `lvl[i]` and a counter `cnt[i]`.
  - If s2[i]==lvl[i]: cnt[i] is cleared to 0.
  - Otherwise cnt[i] increments. When cnt[i] reaches DEBOUNCE_CYCLES-1, on that edge lvl[i] <= s2[i] and cnt[i] <= 0.
  - Any bounce back to lvl[i] before then clears cnt[i]; no change is accepted.
- Press detect:
  - A step request for digit i is raised in the cycle after lvl[i] goes 0->1.
  - A release (1->0) generates nothing.
- Latency:
  - A clean press of raw btn[i] produces step[i] and the num update exactly DEBOUNCE_CYCLES+3 clk edges after the first sampling edge of the new level.
  - Accounting: 2 synchroniser edges, DEBOUNCE_CYCLES counter edges, 1 edge-detect register.
- Step arithmetic, 4-bit modulo per digit, no carry or borrow between digits:
  - Increment: F -> 0 wraps.
  - Decrement: 0 -> F wraps.
  - Other digits are unaffected.
- Simultaneous events:
  - Step requests on several digits in one cycle are all applied in that cycle; each digit is independent.
  - clr=1 in a cycle forces num to 0 and suppresses step for that cycle. Pending requests in that cycle are discarded, not deferred.
  - Debounce state is not affected by clr.
- Holding a button with no auto-repeat: exactly one step per press.
- step is registered and high for exactly one cycle per applied step.
- Reset mid-press: all state clears. If the button is still held after reset, lvl rises after debounce and this counts as a new press, producing one step.

Optional Feature:
- Macro: BTN_HEX_COUNTER_AUTO_REPEAT_EN.
- Defined:
  - Each channel has a hold timer that runs while lvl[i]==1.
  - After REPEAT_DELAY cycles of hold from the initial step, a further step fires.
  - Steps then fire every REPEAT_PERIOD cycles until lvl[i] falls.
  - The timer clears on release, on reset and on clr.
  - Repeat steps follow the same wrap and direction rules, and dec is sampled per step.
- Not defined: the hold timers and their logic are absent; the REPEAT_* parameters are accepted but unused; exactly one step per press.

Test Plan (bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3):
- Reset, then a clean press of btn[0] held 20 cycles, dec=0: num goes 0000 -> 0001 at edge 7 after the level change; step=0001 pulses for one cycle; no further change while held (macro undefined).
- Bounce: btn[2] toggles every 2 cycles for 12 cycles, then settles high: exactly one step, num=0100; no steps during the bounce.
- Wrap: 16 presses of btn[3] with dec=0 give num=0000 with step[3] pulsed 16 times. Then one press with dec=1 gives num=F000.
- Simultaneous press and clear:
  - btn[1] and btn[0] debounce in the same cycle from num=0000: num=0011, step=0011.
  - With clr=1 in that update cycle instead: num=0000, step=0000.
- Reset mid-debounce: btn[1] held, rst_n pulsed low at debounce count 2: num=0000 immediately (asynchronous), then one step to 0010 after a full re-debounce.
- With BTN_HEX_COUNTER_AUTO_REPEAT_EN: hold btn[0] for 20 cycles after the first step; steps occur at hold offsets 0, 8, 11, 14, 17 and 20, giving num=0006.
